// File: rtl/apu_frame_seq.sv
// APU frame sequencer: divides CPU-cycle ticks into quarter/half-frame strobes, 4-/5-step modes.
// Optional frame IRQ flag enabled by defining APU_FRAME_IRQ_EN.
module apu_frame_seq #(
  parameter int CNT_BITS    = 16,
  parameter int STEP_1      = 7457,
  parameter int STEP_2      = 14913,
  parameter int STEP_3      = 22371,
  parameter int STEP_4      = 29829,
  parameter int STEP_5      = 37281,
  parameter int RESET_DELAY = 3
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic cpu_cycle_pulse_in,
  input  logic mode_wr_in,
  input  logic mode_in,
  input  logic irq_inhibit_in,
  input  logic irq_ack_in,
  output logic quarter_frame_pulse_out,
  output logic half_frame_pulse_out,
  output logic frame_irq_out,
  output logic mode_out
);

  typedef enum logic {RUN, PENDING} state_t;

  localparam logic [CNT_BITS-1:0] S1  = CNT_BITS'(STEP_1);
  localparam logic [CNT_BITS-1:0] S2  = CNT_BITS'(STEP_2);
  localparam logic [CNT_BITS-1:0] S3  = CNT_BITS'(STEP_3);
  localparam logic [CNT_BITS-1:0] S4  = CNT_BITS'(STEP_4);
  localparam logic [CNT_BITS-1:0] S5  = CNT_BITS'(STEP_5);
  localparam logic [2:0]          DLY = 3'(RESET_DELAY);

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d, cnt_next;
  logic [2:0]          dly_q, dly_d;
  logic                mode_q, mode_d;
  logic                qf_q, qf_d, hf_q, hf_d;
  logic                hit1, hit2, hit3, hit4, hit5;
  logic                irq_set;

  assign cnt_next = cnt_q + CNT_BITS'(1);
  assign hit1 = (cnt_next == S1);
  assign hit2 = (cnt_next == S2);
  assign hit3 = (cnt_next == S3);
  assign hit4 = (cnt_next == S4);
  assign hit5 = (cnt_next == S5);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= RUN;
      cnt_q   <= '0;
      dly_q   <= '0;
      mode_q  <= 1'b0;
      qf_q    <= 1'b0;
      hf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
      mode_q  <= mode_d;
      qf_q    <= qf_d;
      hf_q    <= hf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dly_d   = dly_q;
    mode_d  = mode_q;
    qf_d    = 1'b0;
    hf_d    = 1'b0;
    irq_set = 1'b0;
    if (mode_wr_in) begin
      // write swallows a coincident tick
      mode_d  = mode_in;
      state_d = PENDING;
      dly_d   = DLY;
    end else if (cpu_cycle_pulse_in) begin
      if (mode_q) begin
        qf_d  = hit1 | hit2 | hit3 | hit5;
        hf_d  = hit2 | hit5;
        cnt_d = hit5 ? '0 : cnt_next;
      end else begin
        qf_d    = hit1 | hit2 | hit3 | hit4;
        hf_d    = hit2 | hit4;
        cnt_d   = hit4 ? '0 : cnt_next;
        irq_set = hit4;
      end
      if (state_q == PENDING) begin
        dly_d = dly_q - 3'd1;
        if (dly_q == 3'd1) begin
          cnt_d   = '0;
          state_d = RUN;
          if (mode_q) begin
            qf_d = 1'b1;
            hf_d = 1'b1;
          end
        end
      end
    end
  end

`ifdef APU_FRAME_IRQ_EN
  logic inhibit_q, irq_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      inhibit_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (mode_wr_in) inhibit_q <= irq_inhibit_in;
      if (irq_set && !inhibit_q)
        irq_q <= 1'b1;
      else if (irq_ack_in || (mode_wr_in && irq_inhibit_in))
        irq_q <= 1'b0;
    end
  end

  assign frame_irq_out = irq_q;
`else
  logic unused_irq;
  assign unused_irq    = ^{irq_ack_in, irq_inhibit_in, irq_set};
  assign frame_irq_out = 1'b0;
`endif

  assign quarter_frame_pulse_out = qf_q;
  assign half_frame_pulse_out    = hf_q;
  assign mode_out                = mode_q;

endmodule
